instr_encoder: RTL

RV32I instruction encoder for the CPU's program-load path. It accepts decoded instruction fields, using the same operation classes, funct3 codes and alternate-op bit that the control decoder consumes, over a valid/ready input. It packs them into 32-bit RV32I machine words, range-checks immediates and field combinations, and buffers legal words with their target addresses in a small FIFO. The FIFO drains through a valid/ready output into instruction memory.

---
 rtl/instr_encoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit words, drops illegal bundles (sticky err),
// and queues {addr, word} pairs in a DEPTH-entry FIFO drained through a valid/ready output.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_alt,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [31:0]       mem_instr [DEPTH];
  logic [31:0]       mem_addr  [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       addr_q, addr_d;
  logic              err_q, err_d;

  logic [31:0]       word;
  logic              legal, accept, push, pop, is_shift;
  logic              fits_i12, fits_b13, fits_j21;
  logic signed [31:0] imm_s;

  assign imm_s    = $signed(in_imm);
  assign fits_i12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  // Branch/jump offsets are halfword multiples; bit 0 is never encoded.
  assign fits_b13 = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
  assign fits_j21 = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (in_op)
      4'd0: begin
        word  = {(in_alt ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1, in_funct3, in_rd, OPC_R};
        legal = !in_alt || (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
      end
      4'd1: begin
        if (is_shift) begin
          word  = {1'b0, in_alt, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_I};
          legal = (in_imm[31:5] == 27'd0) && !(in_alt && (in_funct3 == 3'b001));
        end else begin
          word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_I};
          legal = fits_i12;
        end
      end
      4'd2: begin
        word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
        legal = fits_i12 && !(in_funct3 inside {3'b011, 3'b110, 3'b111});
      end
      4'd3: begin
        word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
        legal = fits_i12 && (in_funct3 inside {3'b000, 3'b001, 3'b010});
      end
      4'd4: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], OPC_BRANCH};
        legal = fits_b13 && !(in_funct3 inside {3'b010, 3'b011});
      end
      4'd5: begin
        word  = {in_imm[31:12], in_rd, OPC_AUIPC};
        legal = (in_imm[11:0] == 12'd0);
      end
      4'd6: begin
        word  = {in_imm[31:12], in_rd, OPC_LUI};
        legal = (in_imm[11:0] == 12'd0);
      end
      4'd7: begin
        word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        legal = fits_j21;
      end
      4'd8: begin
        word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
        legal = fits_i12 && (in_funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
  end

  // in_ready depends only on registered occupancy and clear, never on out_ready.
  assign in_ready  = !clear && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? mem_instr[rd_ptr_q] : 32'd0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr_q]  : 32'd0;
  assign count     = count_q;
  assign err       = err_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = err_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        addr_d   = addr_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (accept && !legal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= word;
      mem_addr[wr_ptr_q]  <= addr_q;
    end
  end

endmodule
